wide_add_sequencer: RTL and testbench
=====================================

// Module: wide_add_sequencer
// PURPOSE
//  Shares one N-bit carry-in ripple adder slice between NREQ requesters.
//  Performs full W = N*WORDS bit additions by running the slice WORDS times, LSB word first.
//  Keeps the inter-word carry in a register. Round-robin arbitration picks the requester.
//  Sits in front of the ripple-adder datapath; trades latency for one N-bit adder instead of a W-bit one.
// PARAMETERS
//  N      8  slice width in bits (adder bits per cycle)
//  WORDS  4  slices per operand; W = N*WORDS
//  NREQ   2  number of requesters; ID_W = max(1,$clog2(NREQ))
// PORTS
//  clk        in   1           single clock, rising edge
//  rst        in   1           asynchronous, active-high reset
//  req_valid  in   NREQ        per-requester request valid
//  req_ready  out  NREQ        per-requester accept (one-hot or zero)
//  req_a      in   NREQ*W      operand A; requester i at [i*W +: W]
//  req_b      in   NREQ*W      operand B; same packing as req_a
//  resp_valid out  1           result valid
//  resp_ready in   1           result consumer ready
//  resp_sum   out  W+1         A+B; bit W = final carry
//  resp_id    out  ID_W        index of requester that owns resp_sum
//  busy       out  1           high in RUN or DONE
// BEHAVIOUR
//  Reset values
//   - state IDLE; rr_ptr 0 (requester 0 highest priority); carry 0; word index 0.
//   - resp_valid 0, resp_sum 0, resp_id 0, busy 0.
//   - req_ready is all 0 while rst is high.
//  FSM IDLE -> RUN -> DONE -> IDLE
//  IDLE
//   - Grant = first valid requester searching from rr_ptr upward, modulo NREQ.
//   - req_ready[grant]=1 combinationally; all other bits 0. No valid requester: all 0, stay IDLE.
//   - On accept: latch A, B and id; clear carry and word index k to 0; rr_ptr <= grant+1 mod NREQ; go RUN.
//  RUN (exactly WORDS cycles)
//   - Slice computes A[k*N+:N] + B[k*N+:N] + carry.
//   - resp_sum[k*N+:N] <= slice sum; carry <= slice cout; k++.
//   - At k==WORDS-1: resp_sum[W] <= cout; go DONE.
//   - req_ready all 0.
//  DONE
//   - resp_valid=1. resp_sum and resp_id held stable until resp_ready.
//   - On resp_valid&&resp_ready: go IDLE. No same-cycle re-accept.
//  Timing
//   - Accept in cycle 0; RUN in cycles 1..WORDS; resp_valid first high in cycle WORDS+1.
//   - Best-case throughput: one add per WORDS+2 cycles.
//  Protocol rules (checked by bench assertions)
//   - req_valid[i] stays high, with req_a/req_b stable, until accepted.
//   - resp_valid never drops without a handshake.
//  Arithmetic
//   - Unsigned, modulo-free: W+1 result bits, so no overflow is possible.
//   - Carry is never shared across transactions.
//  Boundaries
//   - Reset mid-RUN or mid-DONE: transaction dropped, no response; the requester must re-issue.
//   - All-ones operands: carry ripples through every slice.
//   - NREQ=1: rr_ptr stays 0.
// STRUCTURE
//  Package wide_add_pkg
//   - enum seq_state_t {IDLE,RUN,DONE}.
//   - Function rr_pick(valid, ptr) returning the grant index.
//  Sub-module carry_in_adder #(N)
//   - Ports: a, b, c_in, s[N-1:0], c_out.
//   - Built from the existing half/full adder cells; the only arithmetic in this block.
//  Top level holds the FSM, operand/carry/result registers and the arbiter.
// TESTING (N=8, WORDS=4, NREQ=2)
//  1. req0 A=0x000000FF, B=0x00000001 -> resp_sum=0x0_00000100, resp_id=0, resp_valid 5 cycles after accept.
//  2. A=B=0xFFFFFFFF -> resp_sum=0x1_FFFFFFFE (full carry ripple across all 4 slices).
//  3. req0 and req1 valid continuously, resp_ready=1, 4 transactions -> resp_id sequence 0,1,0,1.
//  4. resp_ready low 10 cycles in DONE -> resp_valid, resp_sum and resp_id held; req_ready=00; next accept the cycle after handshake.
//  5. Assert rst during RUN at k=2 -> outputs zero immediately, no response; then 1+1 -> resp_sum=0x0_00000002.
//  6. Back-to-back 0xFFFFFFFF+1 (sum 0x1_00000000) then 0+0 -> second resp_sum=0 (carry cleared between transactions).

Source files
------------

// File: rtl/wide_add_pkg.sv
// Shared types and the round-robin pick helper for the wide add sequencer.
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Upper bound on requesters the pick helper can scan.
    localparam int unsigned MAX_REQ = 16;

    // Returns the first valid index at or above ptr, wrapping modulo nreq.
    function automatic int unsigned rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input int unsigned        ptr,
        input int unsigned        nreq
    );
        int unsigned grant;
        int unsigned idx;
        logic        found;
        grant = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = (ptr + i) % nreq;
            if ((i < nreq) && !found && valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/carry_in_adder.sv
// N-bit ripple slice with carry in; each bit is a full adder made of two half adders.
module carry_in_adder #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] s,
    output logic         c_out
);

    logic [N:0] c_s;

    assign c_s[0] = c_in;

    for (genvar i = 0; i < N; i++) begin : g_fa
        logic p_s;
        logic g_s;
        logic t_s;
        assign p_s      = a[i] ^ b[i];
        assign g_s      = a[i] & b[i];
        assign s[i]     = p_s ^ c_s[i];
        assign t_s      = p_s & c_s[i];
        assign c_s[i+1] = g_s | t_s;
    end

    assign c_out = c_s[N];

endmodule

// File: rtl/wide_add_sequencer.sv
// Time-multiplexes one N-bit adder slice across WORDS cycles to add W-bit operands,
// arbitrating round-robin between NREQ requesters.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter  int unsigned N     = 8,
    parameter  int unsigned WORDS = 4,
    parameter  int unsigned NREQ  = 2,
    localparam int unsigned W     = N * WORDS,
    localparam int unsigned ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [W:0]        resp_sum,
    output logic [ID_W-1:0]   resp_id,
    output logic              busy
);

    localparam int unsigned K_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    seq_state_t       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W:0]       sum_q, sum_d;
    logic [K_W-1:0]   k_q, k_d;
    logic             carry_q, carry_d;
    logic             resp_valid_q, resp_valid_d;
    logic             busy_q, busy_d;

    logic [MAX_REQ-1:0] valid_ext_s;
    logic [ID_W-1:0]    grant_s;
    logic               any_valid_s;
    logic [NREQ-1:0]    req_ready_s;
    logic [N-1:0]       slice_a_s;
    logic [N-1:0]       slice_b_s;
    logic [N-1:0]       slice_s_s;
    logic               slice_cout_s;

    assign valid_ext_s = MAX_REQ'(req_valid);
    assign any_valid_s = |req_valid;
    assign grant_s     = ID_W'(rr_pick(valid_ext_s, 32'(rr_ptr_q), NREQ));

    // Select the active word of each latched operand for the shared slice.
    always_comb begin
        slice_a_s = a_q[k_q*N +: N];
        slice_b_s = b_q[k_q*N +: N];
    end

    carry_in_adder #(.N(N)) u_slice (
        .a     (slice_a_s),
        .b     (slice_b_s),
        .c_in  (carry_q),
        .s     (slice_s_s),
        .c_out (slice_cout_s)
    );

    // Grant is combinational so a waiting requester is accepted in the same cycle.
    always_comb begin
        req_ready_s = '0;
        if (!rst && (state_q == IDLE) && any_valid_s) begin
            req_ready_s[grant_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    // Next-state and datapath update for the accept / run / done sequence.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        k_d          = k_q;
        carry_d      = carry_q;
        resp_valid_d = resp_valid_q;
        busy_d       = busy_q;
        case (state_q)
            IDLE: begin
                if (any_valid_s) begin
                    a_d      = req_a[grant_s*W +: W];
                    b_d      = req_b[grant_s*W +: W];
                    id_d     = grant_s;
                    carry_d  = 1'b0;
                    k_d      = '0;
                    rr_ptr_d = ID_W'((32'(grant_s) + 32'd1) % NREQ);
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[k_q*N +: N] = slice_s_s;
                carry_d           = slice_cout_s;
                if (32'(k_q) == WORDS - 32'd1) begin
                    sum_d[W]     = slice_cout_s;
                    k_d          = '0;
                    resp_valid_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            DONE: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            k_q          <= '0;
            carry_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sum_q        <= sum_d;
            k_q          <= k_d;
            carry_q      <= carry_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = req_ready_s;
    assign resp_valid = resp_valid_q;
    assign resp_sum   = sum_q;
    assign resp_id    = id_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Randomized bench for wide_add_sequencer against a plain-arithmetic round-robin model.
module tb_wide_add_sequencer;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [32:0] resp_sum;
    logic        resp_id;
    logic        busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int model_ptr = 0;

    wide_add_sequencer #(.N(8), .WORDS(4), .NREQ(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A pending result must stay valid until it is taken.
    a_resp_hold: assert property (@(posedge clk) disable iff (rst)
        (resp_valid && !resp_ready) |=> resp_valid)
        else $error("resp_valid dropped without handshake");

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int model_pick(input logic [1:0] vmask);
        int idx;
        for (int i = 0; i < 2; i++) begin
            idx = (model_ptr + i) % 2;
            if (vmask[idx]) return idx;
        end
        return -1;
    endfunction

    // One full transaction; starts at a negedge with the DUT idle, ends at a negedge after handshake.
    task automatic run_txn(input logic [1:0] vmask, input logic [31:0] a0, input logic [31:0] b0,
                           input logic [31:0] a1, input logic [31:0] b1, input int hold,
                           input bit keep, output int g);
        logic [32:0] exp_sum;
        logic [1:0]  exp_rdy;
        int          lat;
        req_valid = vmask;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        g = model_pick(vmask);
        exp_rdy = 2'b00;
        exp_rdy[g] = 1'b1;
        #1;
        check_eq("grant", 64'(req_ready), 64'(exp_rdy));
        exp_sum = (g == 1) ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
        model_ptr = (g + 1) % 2;
        @(posedge clk);
        @(negedge clk);
        if (!keep) req_valid[g] = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 64'(lat), 64'd5);
        check_eq("busy_done", 64'(busy), 64'd1);
        check_eq("ready_done", 64'(req_ready), 64'd0);
        resp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 64'(resp_valid), 64'd1);
            check_eq("hold_sum", 64'(resp_sum), 64'(exp_sum));
            check_eq("hold_id", 64'(resp_id), 64'(g));
            check_eq("hold_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        check_eq("sum", 64'(resp_sum), 64'(exp_sum));
        check_eq("id", 64'(resp_id), 64'(g));
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check_eq("valid_after", 64'(resp_valid), 64'd0);
        check_eq("busy_after", 64'(busy), 64'd0);
    endtask

    initial begin
        int          g;
        int          highs;
        logic [1:0]  pend;
        logic [31:0] opa [2];
        logic [31:0] opb [2];

        rst        = 1'b1;
        req_valid  = 2'b11;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 64'(req_ready), 64'd0);
        check_eq("rst_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_sum", 64'(resp_sum), 64'd0);
        check_eq("rst_id", 64'(resp_id), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        req_valid = 2'b00;
        rst = 1'b0;
        model_ptr = 0;
        @(negedge clk);

        // Directed cases: carry into word 1, full ripple, alternation, long stall.
        run_txn(2'b01, 32'h0000_00FF, 32'h0000_0001, 32'h0, 32'h0, 0, 1'b0, g);
        check_eq("t1_sum_const", 64'(resp_sum), 64'h0_0000_0100);
        run_txn(2'b10, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, g);
        check_eq("t2_sum_const", 64'(resp_sum), 64'h1_FFFF_FFFE);
        for (int i = 0; i < 4; i++) begin
            run_txn(2'b11, 32'h1234_5678 + 32'(i), 32'h1, 32'h9ABC_DEF0, 32'h2, 0, 1'b1, g);
            check_eq("t3_id_seq", 64'(resp_id), 64'(i % 2));
        end
        req_valid = 2'b00;
        run_txn(2'b01, 32'hDEAD_BEEF, 32'h2152_4111, 32'h0, 32'h0, 10, 1'b0, g);

        // Reset while the slice is on word 2.
        req_valid = 2'b01;
        req_a = {32'h0, 32'h0000_0005};
        req_b = {32'h0, 32'h0000_0007};
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrun_sum", 64'(resp_sum), 64'd0);
        check_eq("midrun_valid", 64'(resp_valid), 64'd0);
        check_eq("midrun_busy", 64'(busy), 64'd0);
        check_eq("midrun_id", 64'(resp_id), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_valid) highs++;
        end
        check_eq("no_resp_after_rst", 64'(highs), 64'd0);
        run_txn(2'b01, 32'h1, 32'h1, 32'h0, 32'h0, 0, 1'b0, g);
        check_eq("t5_sum_const", 64'(resp_sum), 64'h0_0000_0002);

        // Carry must not leak into the next transaction.
        run_txn(2'b01, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 0, 1'b0, g);
        run_txn(2'b01, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b0, g);
        check_eq("t6_sum_const", 64'(resp_sum), 64'h0);

        // Random traffic; an unserved requester keeps its request and operands.
        pend = 2'b00;
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1'b1;
                    opa[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                    opb[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                end
            end
            if (pend == 2'b00) begin
                pend[0] = 1'b1;
                opa[0] = $urandom;
                opb[0] = $urandom;
            end
            run_txn(pend, opa[0], opb[0], opa[1], opb[1], $urandom_range(0, 3), 1'b0, g);
            pend[g] = 1'b0;
        end
        req_valid = 2'b00;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
